// File: rtl/rx_loader_ctrl_if.sv
// Bus between the UART receiver / CPU side and the program loader.
// The master drives the received byte stream and the CPU halt level.
// The slave (the loader) drives the instruction-memory write port,
// the status pulses and the CPU execution gates.
interface rx_loader_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 10
);
  logic               rx_done_tick;
  logic [NB_DATA-1:0] rx_data;
  logic               cpu_halt;
  logic               mem_we;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_WORD-1:0] mem_data;
  logic               load_done;
  logic               load_err;
  logic               cmd_err;
  logic               run_en;
  logic               step_pulse;

  modport master (
    output rx_done_tick, rx_data, cpu_halt,
    input  mem_we, mem_addr, mem_data, load_done, load_err, cmd_err, run_en, step_pulse
  );

  modport slave (
    input  rx_done_tick, rx_data, cpu_halt,
    output mem_we, mem_addr, mem_data, load_done, load_err, cmd_err, run_en, step_pulse
  );
endinterface

// File: rtl/rx_loader_ctrl.sv
// Command decoder and program loader behind the debug UART receiver.
// IDLE decodes single-byte commands ('L' load, 'C' continuous run,
// 'S' single step). LOAD packs little-endian bytes into 32-bit words and
// writes them to consecutive instruction-memory addresses until a halt
// word (all ones) or the last address is written. An inter-byte timeout
// abandons a stalled load. RUN and STEP gate the CPU until it halts.
// NB_WORD must equal 4*NB_DATA and TIMEOUT must be at least 2.
module rx_loader_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic           clock,
  input  logic           reset,
  rx_loader_ctrl_if.slave bus
);

  localparam int NB_TMO = $clog2(TIMEOUT);
  localparam logic [NB_TMO-1:0]  TMO_LAST  = NB_TMO'(TIMEOUT - 1);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
  localparam logic [NB_DATA-1:0] CMD_LOAD  = NB_DATA'(8'h4C);
  localparam logic [NB_DATA-1:0] CMD_CONT  = NB_DATA'(8'h43);
  localparam logic [NB_DATA-1:0] CMD_STEP  = NB_DATA'(8'h53);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STEP} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         byte_cnt_reg, byte_cnt_next;
  logic [NB_WORD-1:0] word_reg, word_next;
  logic [NB_ADDR-1:0] addr_reg, addr_next;
  logic [NB_TMO-1:0]  tmo_reg, tmo_next;
  logic               mem_we_reg, mem_we_next;
  logic [NB_WORD-1:0] mem_data_reg, mem_data_next;
  logic               last_reg, last_next;
  logic               load_done_reg, load_done_next;
  logic               load_err_reg, load_err_next;
  logic               cmd_err_reg, cmd_err_next;
  logic               step_pulse_reg, step_pulse_next;

  // Partial word with the incoming byte dropped into the lane picked by
  // the byte counter; lane 0 is the least significant byte.
  logic [NB_WORD-1:0] word_merged;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_merged[gi*NB_DATA +: NB_DATA] =
      (byte_cnt_reg == 2'(gi)) ? bus.rx_data : word_reg[gi*NB_DATA +: NB_DATA];
  end

  // State and output registers; reset forces IDLE and drops any pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= '0;
      word_reg       <= '0;
      addr_reg       <= '0;
      tmo_reg        <= '0;
      mem_we_reg     <= 1'b0;
      mem_data_reg   <= '0;
      last_reg       <= 1'b0;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
      cmd_err_reg    <= 1'b0;
      step_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_reg       <= word_next;
      addr_reg       <= addr_next;
      tmo_reg        <= tmo_next;
      mem_we_reg     <= mem_we_next;
      mem_data_reg   <= mem_data_next;
      last_reg       <= last_next;
      load_done_reg  <= load_done_next;
      load_err_reg   <= load_err_next;
      cmd_err_reg    <= cmd_err_next;
      step_pulse_reg <= step_pulse_next;
    end
  end

  // Next-state and registered-output decode; pulses default low every cycle.
  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_next       = word_reg;
    addr_next       = addr_reg;
    tmo_next        = tmo_reg;
    mem_we_next     = 1'b0;
    mem_data_next   = mem_data_reg;
    last_next       = last_reg;
    load_done_next  = load_done_reg;
    load_err_next   = 1'b0;
    cmd_err_next    = 1'b0;
    step_pulse_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.rx_done_tick) begin
          if (bus.rx_data == CMD_LOAD) begin
            state_next     = LOAD;
            load_done_next = 1'b0;
            addr_next      = '0;
            byte_cnt_next  = '0;
            tmo_next       = '0;
            last_next      = 1'b0;
          end else if (bus.rx_data == CMD_CONT && load_done_reg) begin
            state_next = RUN;
          end else if (bus.rx_data == CMD_STEP && load_done_reg) begin
            state_next = STEP;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end

      LOAD: begin
        if (mem_we_reg && last_reg) begin
          // Final word is being written this cycle: program is complete.
          state_next     = IDLE;
          load_done_next = 1'b1;
        end else begin
          // Address advances once the current write has been presented.
          if (mem_we_reg) begin
            addr_next = addr_reg + NB_ADDR'(1);
          end
          if (bus.rx_done_tick) begin
            tmo_next      = '0;
            word_next     = word_merged;
            byte_cnt_next = byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              // A 4th byte never coincides with a write, so addr_reg is the
              // address this word will land at.
              mem_we_next   = 1'b1;
              mem_data_next = word_merged;
              last_next     = (word_merged == '1) || (addr_reg == ADDR_LAST);
            end
          end else if (tmo_reg == TMO_LAST) begin
            // Counter reaches TIMEOUT on this edge: abandon the partial word.
            state_next    = IDLE;
            load_err_next = 1'b1;
            tmo_next      = '0;
            byte_cnt_next = '0;
          end else begin
            tmo_next = tmo_reg + NB_TMO'(1);
          end
        end
      end

      RUN: begin
        if (bus.cpu_halt) begin
          state_next = IDLE;
        end
      end

      STEP: begin
        // Halt takes priority over a simultaneous step request.
        if (bus.cpu_halt) begin
          state_next = IDLE;
        end else if (bus.rx_done_tick && bus.rx_data == CMD_STEP) begin
          step_pulse_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_data   = mem_data_reg;
  assign bus.load_done  = load_done_reg;
  assign bus.load_err   = load_err_reg;
  assign bus.cmd_err    = cmd_err_reg;
  assign bus.run_en     = (state_reg == RUN);
  assign bus.step_pulse = step_pulse_reg;

endmodule

// File: tb/tb_rx_loader_ctrl.sv
// Bench for rx_loader_ctrl with a 4-word memory and a 16-cycle timeout.
// Expected memory writes are derived from the byte stream by plain
// little-endian packing and the halt / last-address stop rule; command and
// step behaviour is checked against directly counted expectations.
module tb_rx_loader_ctrl;
  localparam int NB_DATA = 8;
  localparam int NB_WORD = 32;
  localparam int NB_ADDR = 2;
  localparam int TIMEOUT = 16;
  localparam int N_WORDS = 1 << NB_ADDR;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_tests    = 0;
  int n_fail     = 0;
  int n_step     = 0;
  int n_cmd_err  = 0;
  int n_load_err = 0;
  logic [NB_ADDR+NB_WORD-1:0] wr_q[$];

  rx_loader_ctrl_if #(.NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .NB_ADDR(NB_ADDR)) bus ();

  rx_loader_ctrl #(
    .NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .NB_ADDR(NB_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Log writes and count pulse cycles, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_data});
    if (bus.cmd_err === 1'b1) n_cmd_err++;
    if (bus.load_err === 1'b1) n_load_err++;
    if (bus.step_pulse === 1'b1) n_step++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.mem_we, bus.mem_addr, bus.mem_data, bus.load_done,
                bus.load_err, bus.cmd_err, bus.run_en, bus.step_pulse});
  endfunction

  function automatic logic [7:0] rand_other();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h4C || b == 8'h43 || b == 8'h53);
    return b;
  endfunction

  task automatic tick_cycle();
    @(posedge clock);
    #1;
  endtask

  // Present one byte for exactly one cycle; returns in the cycle after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    tick_cycle();
    bus.rx_done_tick = 1'b0;
  endtask

  // 'L' followed by the given bytes, with up to max_gap idle cycles between bytes.
  task automatic do_load(input logic [7:0] bytes[$], input int max_gap);
    logic [31:0] exp_w[$];
    logic [31:0] w;
    bit          exp_done;
    int          base;
    exp_done = 1'b0;
    for (int i = 0; i + 3 < bytes.size() && !exp_done; i += 4) begin
      w = {bytes[i+3], bytes[i+2], bytes[i+1], bytes[i]};
      exp_w.push_back(w);
      if (w == 32'hFFFF_FFFF || exp_w.size() == N_WORDS) exp_done = 1'b1;
    end
    base = wr_q.size();
    send_byte(8'h4C);
    check("load_done_cleared", 64'(bus.load_done), 64'(0));
    for (int i = 0; i < bytes.size(); i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap)) tick_cycle();
      send_byte(bytes[i]);
      if (i % 4 == 3) begin
        check("mem_we_latency", 64'(bus.mem_we), 64'(1));
        check("mem_addr", 64'(bus.mem_addr), 64'(i / 4));
        check("mem_data", 64'(bus.mem_data), 64'(exp_w[i/4]));
      end
    end
    tick_cycle();
    check("load_done_after_write", 64'(bus.load_done), 64'(exp_done));
    check("mem_we_one_cycle", 64'(bus.mem_we), 64'(0));
    check("write_count", 64'(wr_q.size() - base), 64'(exp_w.size()));
    for (int j = 0; j < exp_w.size() && base + j < wr_q.size(); j++)
      check("write_log", 64'(wr_q[base+j]), 64'({NB_ADDR'(j), exp_w[j]}));
    $display("[TB] load of %0d words, load_done=%0b", exp_w.size(), bus.load_done);
  endtask

  initial begin
    logic [7:0]  bq[$];
    logic [7:0]  b;
    logic [31:0] w;
    int          base;
    int          k;
    int          exp_s;
    int          nw;

    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    bus.cpu_halt     = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick_cycle();
    check("reset_outputs", outs(), 64'(0));
    reset = 1'b0;
    tick_cycle();
    check("idle_outputs", outs(), 64'(0));

    // Commands rejected before any program is loaded
    send_byte(8'h43);
    check("C_unloaded_cmd_err", 64'(bus.cmd_err), 64'(1));
    check("C_unloaded_run_en", 64'(bus.run_en), 64'(0));
    tick_cycle();
    check("cmd_err_width", 64'(bus.cmd_err), 64'(0));
    check("C_unloaded_run_en_later", 64'(bus.run_en), 64'(0));
    send_byte(8'h53);
    check("S_unloaded_cmd_err", 64'(bus.cmd_err), 64'(1));
    send_byte(rand_other());
    check("unknown_cmd_err", 64'(bus.cmd_err), 64'(1));
    tick_cycle();
    check("cmd_err_pulse_count", 64'(n_cmd_err), 64'(3));
    $display("[TB] command gating before load");

    // Two words plus halt, back-to-back bytes
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00,
           8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load(bq, 0);

    // Continuous run: bytes ignored until halt
    base = wr_q.size();
    k    = n_cmd_err;
    send_byte(8'h43);
    check("run_en_after_C", 64'(bus.run_en), 64'(1));
    repeat (8) send_byte(8'($urandom));
    tick_cycle();
    check("run_en_holds", 64'(bus.run_en), 64'(1));
    check("run_ignores_bytes_writes", 64'(wr_q.size() - base), 64'(0));
    check("run_ignores_bytes_cmd_err", 64'(n_cmd_err - k), 64'(0));
    bus.cpu_halt = 1'b1;
    tick_cycle();
    bus.cpu_halt = 1'b0;
    check("run_en_drops_on_halt", 64'(bus.run_en), 64'(0));
    check("load_done_persists", 64'(bus.load_done), 64'(1));
    send_byte(rand_other());
    check("idle_after_run", 64'(bus.cmd_err), 64'(1));
    $display("[TB] continuous run and halt");

    // Single step: only 'S' bytes produce pulses
    send_byte(8'h53);
    check("step_entry_no_pulse", 64'(bus.step_pulse), 64'(0));
    k     = n_step;
    exp_s = 0;
    while (exp_s < 3) begin
      if ($urandom_range(1) == 1) begin
        send_byte(8'h53);
        exp_s++;
        check("step_pulse_on_S", 64'(bus.step_pulse), 64'(1));
      end else begin
        do b = 8'($urandom); while (b == 8'h53);
        send_byte(b);
        check("step_ignores_other", 64'(bus.step_pulse), 64'(0));
      end
      if ($urandom_range(1) == 1) tick_cycle();
    end
    tick_cycle();
    check("step_pulse_count", 64'(n_step - k), 64'(3));
    bus.cpu_halt = 1'b1;
    send_byte(8'h53);
    bus.cpu_halt = 1'b0;
    check("halt_beats_S", 64'(bus.step_pulse), 64'(0));
    tick_cycle();
    check("step_pulse_count_after_halt", 64'(n_step - k), 64'(3));
    send_byte(rand_other());
    check("idle_after_step", 64'(bus.cmd_err), 64'(1));
    $display("[TB] single step and halt");

    // Timeout after two bytes of a word
    base = wr_q.size();
    k    = n_load_err;
    send_byte(8'h4C);
    check("timeout_load_done_cleared", 64'(bus.load_done), 64'(0));
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (TIMEOUT - 1) tick_cycle();
    check("load_err_not_early", 64'(bus.load_err), 64'(0));
    tick_cycle();
    check("load_err_on_time", 64'(bus.load_err), 64'(1));
    check("timeout_load_done", 64'(bus.load_done), 64'(0));
    tick_cycle();
    check("load_err_width", 64'(bus.load_err), 64'(0));
    check("timeout_no_write", 64'(wr_q.size() - base), 64'(0));
    check("load_err_count", 64'(n_load_err - k), 64'(1));
    send_byte(8'h43);
    check("C_after_timeout_cmd_err", 64'(bus.cmd_err), 64'(1));
    $display("[TB] load timeout");

    // Full memory: four non-halt words, then a byte decoded as a command
    bq.delete();
    for (int i = 0; i < N_WORDS; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      for (int j = 0; j < 4; j++) bq.push_back(w[8*j +: 8]);
    end
    do_load(bq, 2);
    send_byte(rand_other());
    check("byte_after_full_is_cmd", 64'(bus.cmd_err), 64'(1));

    // Random loads of 1..4 words, halt-terminated when shorter than memory
    repeat (4) begin
      nw = $urandom_range(1, N_WORDS);
      bq.delete();
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        if (i == nw - 1 && nw < N_WORDS) w = 32'hFFFF_FFFF;
        else if (w == 32'hFFFF_FFFF) w = 32'h1;
        for (int j = 0; j < 4; j++) bq.push_back(w[8*j +: 8]);
      end
      do_load(bq, 3);
    end

    // Reset during a load, coinciding with the 4th byte
    send_byte(8'h4C);
    repeat (3) send_byte(8'($urandom));
    base  = wr_q.size();
    reset = 1'b1;
    send_byte(8'($urandom));
    reset = 1'b0;
    check("reset_mid_load_outputs", outs(), 64'(0));
    tick_cycle();
    check("reset_mid_load_no_write", 64'(wr_q.size() - base), 64'(0));
    check("reset_mid_load_outputs_later", outs(), 64'(0));
    $display("[TB] reset during load");
    bq.delete();
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h2;
    for (int j = 0; j < 4; j++) bq.push_back(w[8*j +: 8]);
    for (int j = 0; j < 4; j++) bq.push_back(8'hFF);
    do_load(bq, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
